// File: rtl/sha_pad_pkg.sv
// Shared constants and types for the SHA-256 message padder.
// Block geometry and the padding marker live here so the padder and its helpers agree.
package sha_pad_pkg;

  localparam int         BLK_WORDS = 16;
  localparam int         LEN_W     = 64;
  localparam logic [7:0] PAD_MARK  = 8'h80;

  typedef logic [31:0]      word_t;
  typedef logic [7:0]       lane_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    EMIT
  } pad_state_t;

endpackage

// File: rtl/pad_lastword.sv
// Masks the unused byte lanes of a message's final word and inserts the 0x80 marker.
// inBytes of 0 means the word is full, so it passes through untouched.
module pad_lastword
  import sha_pad_pkg::*;
(
  input  word_t      inData,
  input  logic [1:0] inBytes,
  output word_t      outWord
);

  always_comb begin
    case (inBytes)
      2'd1:    outWord = {inData[31:24], PAD_MARK, 16'h0000};
      2'd2:    outWord = {inData[31:16], PAD_MARK, 8'h00};
      2'd3:    outWord = {inData[31:8], PAD_MARK};
      default: outWord = inData;
    endcase
  end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 padder: collects big-endian words into 512-bit blocks, appends 0x80, zero fill
// and the 64-bit bit length, and offers each block with a level start until it is taken.
module sha_msg_padder
  import sha_pad_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  input  logic [31:0]  inData,
  input  logic         inLast,
  input  logic [1:0]   inBytes,
  output logic         inReady,
  input  logic         blkBusy,
  output logic         start,
  output logic [511:0] msgOut,
  output logic         blkLast
);

  pad_state_t state, stateNext;
  word_t      blkBuf [BLK_WORDS];
  logic [3:0] widx, widxNext;
  len_t       nbytes, nbytesNext;
  logic       markDone, markNext;
  logic       fits, fitsNext, fitsNow;
  logic       finalBlk, finalNext;
  logic       padPend, pendNext;
  logic       wrEn;
  word_t      wrData;
  word_t      lastWord;
  len_t       lenField;
  logic [2:0] lastCnt;

  pad_lastword u_lastword (
    .inData  (inData),
    .inBytes (inBytes),
    .outWord (lastWord)
  );

  assign lenField = {nbytes[LEN_W-4:0], 3'b000};
  assign lastCnt  = (inBytes == 2'd0) ? 3'd4 : {1'b0, inBytes};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    widxNext   = widx;
    nbytesNext = nbytes;
    markNext   = markDone;
    fitsNext   = fits;
    fitsNow    = fits;
    finalNext  = finalBlk;
    pendNext   = padPend;
    wrEn       = 1'b0;
    wrData     = '0;
    case (state)
      FILL: begin
        if (inValid) begin
          wrEn     = 1'b1;
          widxNext = widx + 4'd1;
          if (inLast) begin
            wrData     = lastWord;
            nbytesNext = nbytes + len_t'(lastCnt);
            markNext   = (inBytes != 2'd0);
            fitsNext   = (widx <= 4'd13);
            pendNext   = 1'b1;
            // A last word in slot 15 leaves no room; the length always goes in the next block.
            if (widx == 4'd15) begin
              stateNext = EMIT;
              finalNext = 1'b0;
              fitsNext  = 1'b1;
            end else begin
              stateNext = PAD;
            end
          end else begin
            wrData     = inData;
            nbytesNext = nbytes + 64'd4;
            if (widx == 4'd15) begin
              stateNext = EMIT;
              finalNext = 1'b0;
            end
          end
        end
      end
      PAD: begin
        wrEn     = 1'b1;
        widxNext = widx + 4'd1;
        if (!markDone) begin
          wrData   = {PAD_MARK, 24'h000000};
          markNext = 1'b1;
          fitsNow  = (widx <= 4'd13);
          fitsNext = fitsNow;
        end else if (fits && widx == 4'd14) begin
          wrData = lenField[63:32];
        end else if (fits && widx == 4'd15) begin
          wrData = lenField[31:0];
        end
        if (widx == 4'd15) begin
          stateNext = EMIT;
          finalNext = fitsNow;
          if (!fitsNow) fitsNext = 1'b1;
        end
      end
      EMIT: begin
        if (!blkBusy) begin
          widxNext = 4'd0;
          if (finalBlk) begin
            nbytesNext = '0;
            markNext   = 1'b0;
            fitsNext   = 1'b0;
            finalNext  = 1'b0;
            pendNext   = 1'b0;
            stateNext  = FILL;
          end else if (padPend) begin
            stateNext = PAD;
          end else begin
            stateNext = FILL;
          end
        end
      end
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      widx     <= 4'd0;
      nbytes   <= '0;
      markDone <= 1'b0;
      fits     <= 1'b0;
      finalBlk <= 1'b0;
      padPend  <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) blkBuf[i] <= '0;
    end else begin
      widx     <= widxNext;
      nbytes   <= nbytesNext;
      markDone <= markNext;
      fits     <= fitsNext;
      finalBlk <= finalNext;
      padPend  <= pendNext;
      if (wrEn) blkBuf[widx] <= wrData;
    end
  end

  // The buffer is only written in FILL/PAD, so msgOut is naturally frozen during EMIT.
  always_comb begin
    msgOut = '0;
    for (int i = 0; i < BLK_WORDS; i++) msgOut[511-32*i -: 32] = blkBuf[i];
  end

  assign inReady = (state == FILL);
  assign start   = (state == EMIT);
  assign blkLast = (state == EMIT) && finalBlk;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: hand-computed SHA-256 padded blocks, block timing,
// backpressure and asynchronous reset behaviour.
module tb_sha_msg_padder;

  logic         clk;
  logic         reset;
  logic         inValid;
  logic [31:0]  inData;
  logic         inLast;
  logic [1:0]   inBytes;
  logic         inReady;
  logic         blkBusy;
  logic         start;
  logic [511:0] msgOut;
  logic         blkLast;

  int compCnt = 0;
  int failCnt = 0;

  sha_msg_padder dut (
    .clk     (clk),
    .reset   (reset),
    .inValid (inValid),
    .inData  (inData),
    .inLast  (inLast),
    .inBytes (inBytes),
    .inReady (inReady),
    .blkBusy (blkBusy),
    .start   (start),
    .msgOut  (msgOut),
    .blkLast (blkLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] dataWord(input int i);
    return 32'hC0DE0000 | i;
  endfunction

  // Presents one word and holds it until the padder accepts it.
  task automatic sendWord(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int waitCyc = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    inBytes = nb;
    while (!inReady && waitCyc < 100) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (waitCyc >= 100) begin
      compCnt++;
      failCnt++;
      $display("[TB] FAIL sendWord timeout: inReady=%0b required 1", inReady);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    inBytes = 2'd0;
  endtask

  // Counts clock edges until start is seen high (capped).
  task automatic waitStart(output int cycles);
    cycles = 0;
    while (!start && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    inValid = 1'b0;
    inData  = '0;
    inLast  = 1'b0;
    inBytes = 2'd0;
    blkBusy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compCnt++; if (start !== 1'b0) begin failCnt++; $display("[TB] FAIL reset start: got %0b want 0", start); end
    compCnt++; if (blkLast !== 1'b0) begin failCnt++; $display("[TB] FAIL reset blkLast: got %0b want 0", blkLast); end
    compCnt++; if (msgOut !== 512'h0) begin failCnt++; $display("[TB] FAIL reset msgOut: got %h want 0", msgOut); end
    compCnt++; if (inReady !== 1'b1) begin failCnt++; $display("[TB] FAIL reset inReady: got %0b want 1", inReady); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc(input string tag);
    int cyc;
    logic [511:0] e;
    e = '0;
    e[511 -: 32] = 32'h61626380;
    e[31:0]      = 32'h00000018;
    sendWord(32'h61626300, 1'b1, 2'd3);
    waitStart(cyc);
    compCnt++; if (cyc !== 15) begin failCnt++; $display("[TB] FAIL %s start latency: got %0d edges want 15", tag, cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL %s block: got %h want %h", tag, msgOut, e); end
    compCnt++; if (blkLast !== 1'b1) begin failCnt++; $display("[TB] FAIL %s blkLast: got %0b want 1", tag, blkLast); end
    compCnt++; if (inReady !== 1'b0) begin failCnt++; $display("[TB] FAIL %s inReady in EMIT: got %0b want 0", tag, inReady); end
    @(posedge clk); #1;
    compCnt++; if (start !== 1'b0) begin failCnt++; $display("[TB] FAIL %s start after transfer: got %0b want 0", tag, start); end
    compCnt++; if (inReady !== 1'b1) begin failCnt++; $display("[TB] FAIL %s inReady after transfer: got %0b want 1", tag, inReady); end
  endtask

  task automatic test_55bytes();
    int cyc;
    logic [511:0] e;
    e = '0;
    for (int i = 0; i < 13; i++) e[511-32*i -: 32] = dataWord(i);
    e[95:64] = 32'h11223380;
    e[31:0]  = 32'h000001B8;
    for (int i = 0; i < 13; i++) sendWord(dataWord(i), 1'b0, 2'd0);
    sendWord(32'h112233FF, 1'b1, 2'd3);
    waitStart(cyc);
    compCnt++; if (cyc !== 2) begin failCnt++; $display("[TB] FAIL 55B start latency: got %0d want 2", cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL 55B block: got %h want %h", msgOut, e); end
    compCnt++; if (blkLast !== 1'b1) begin failCnt++; $display("[TB] FAIL 55B blkLast: got %0b want 1", blkLast); end
    @(posedge clk); #1;
  endtask

  task automatic test_56bytes();
    int cyc;
    logic [511:0] e;
    e = '0;
    for (int i = 0; i < 13; i++) e[511-32*i -: 32] = dataWord(i);
    e[95:64] = 32'hDEADBEEF;
    e[63:32] = 32'h80000000;
    for (int i = 0; i < 13; i++) sendWord(dataWord(i), 1'b0, 2'd0);
    sendWord(32'hDEADBEEF, 1'b1, 2'd0);
    waitStart(cyc);
    compCnt++; if (cyc !== 2) begin failCnt++; $display("[TB] FAIL 56B blk1 latency: got %0d want 2", cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL 56B blk1: got %h want %h", msgOut, e); end
    compCnt++; if (blkLast !== 1'b0) begin failCnt++; $display("[TB] FAIL 56B blk1 blkLast: got %0b want 0", blkLast); end
    @(posedge clk); #1;
    compCnt++; if (start !== 1'b0) begin failCnt++; $display("[TB] FAIL 56B start after blk1: got %0b want 0", start); end
    e = '0;
    e[31:0] = 32'h000001C0;
    waitStart(cyc);
    compCnt++; if (cyc !== 16) begin failCnt++; $display("[TB] FAIL 56B blk2 latency: got %0d want 16", cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL 56B blk2: got %h want %h", msgOut, e); end
    compCnt++; if (blkLast !== 1'b1) begin failCnt++; $display("[TB] FAIL 56B blk2 blkLast: got %0b want 1", blkLast); end
    @(posedge clk); #1;
  endtask

  task automatic test_64bytes();
    int cyc;
    logic [511:0] e;
    e = '0;
    for (int i = 0; i < 16; i++) e[511-32*i -: 32] = dataWord(i + 32);
    for (int i = 0; i < 15; i++) sendWord(dataWord(i + 32), 1'b0, 2'd0);
    sendWord(dataWord(47), 1'b1, 2'd0);
    waitStart(cyc);
    compCnt++; if (cyc !== 0) begin failCnt++; $display("[TB] FAIL 64B blk1 latency: got %0d want 0", cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL 64B blk1: got %h want %h", msgOut, e); end
    compCnt++; if (blkLast !== 1'b0) begin failCnt++; $display("[TB] FAIL 64B blk1 blkLast: got %0b want 0", blkLast); end
    @(posedge clk); #1;
    e = '0;
    e[511 -: 32] = 32'h80000000;
    e[31:0]      = 32'h00000200;
    waitStart(cyc);
    compCnt++; if (cyc !== 16) begin failCnt++; $display("[TB] FAIL 64B blk2 latency: got %0d want 16", cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL 64B blk2: got %h want %h", msgOut, e); end
    compCnt++; if (blkLast !== 1'b1) begin failCnt++; $display("[TB] FAIL 64B blk2 blkLast: got %0b want 1", blkLast); end
    @(posedge clk); #1;
  endtask

  // A full 4-byte single-word message, with the next message's word held on inValid
  // through PAD and a 10-cycle stall; the held word must only be taken after the transfer.
  task automatic test_backpressure();
    int cyc;
    logic [511:0] e;
    e = '0;
    e[511 -: 32] = 32'h41424344;
    e[479 -: 32] = 32'h80000000;
    e[31:0]      = 32'h00000020;
    blkBusy = 1'b1;
    sendWord(32'h41424344, 1'b1, 2'd0);
    inValid = 1'b1;
    inData  = 32'h61626300;
    inLast  = 1'b1;
    inBytes = 2'd3;
    waitStart(cyc);
    compCnt++; if (cyc !== 15) begin failCnt++; $display("[TB] FAIL bp latency: got %0d want 15", cyc); end
    for (int i = 0; i < 10; i++) begin
      compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL bp msgOut cyc %0d: got %h want %h", i, msgOut, e); end
      compCnt++; if (inReady !== 1'b0) begin failCnt++; $display("[TB] FAIL bp inReady cyc %0d: got %0b want 0", i, inReady); end
      compCnt++; if (start !== 1'b1) begin failCnt++; $display("[TB] FAIL bp start cyc %0d: got %0b want 1", i, start); end
      @(posedge clk); #1;
    end
    compCnt++; if (blkLast !== 1'b1) begin failCnt++; $display("[TB] FAIL bp blkLast: got %0b want 1", blkLast); end
    blkBusy = 1'b0;
    @(posedge clk); #1;
    compCnt++; if (start !== 1'b0) begin failCnt++; $display("[TB] FAIL bp start after transfer: got %0b want 0", start); end
    compCnt++; if (inReady !== 1'b1) begin failCnt++; $display("[TB] FAIL bp inReady after transfer: got %0b want 1", inReady); end
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    inBytes = 2'd0;
    e = '0;
    e[511 -: 32] = 32'h61626380;
    e[31:0]      = 32'h00000018;
    waitStart(cyc);
    compCnt++; if (cyc !== 15) begin failCnt++; $display("[TB] FAIL bp held abc latency: got %0d want 15", cyc); end
    compCnt++; if (msgOut !== e) begin failCnt++; $display("[TB] FAIL bp held abc block: got %h want %h", msgOut, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midblock();
    int cyc;
    // Reset while padding: the partly built buffer must vanish.
    sendWord(32'h61626300, 1'b1, 2'd3);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    compCnt++; if (msgOut !== 512'h0) begin failCnt++; $display("[TB] FAIL rst midPAD msgOut: got %h want 0", msgOut); end
    compCnt++; if (inReady !== 1'b1) begin failCnt++; $display("[TB] FAIL rst midPAD inReady: got %0b want 1", inReady); end
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    // Reset while a block is being offered: start must fall without a clock edge.
    blkBusy = 1'b1;
    sendWord(32'h61626300, 1'b1, 2'd3);
    waitStart(cyc);
    compCnt++; if (start !== 1'b1) begin failCnt++; $display("[TB] FAIL rst setup start: got %0b want 1", start); end
    #1;
    reset = 1'b0;
    #1;
    compCnt++; if (start !== 1'b0) begin failCnt++; $display("[TB] FAIL rst midEMIT start: got %0b want 0", start); end
    compCnt++; if (msgOut !== 512'h0) begin failCnt++; $display("[TB] FAIL rst midEMIT msgOut: got %h want 0", msgOut); end
    compCnt++; if (blkLast !== 1'b0) begin failCnt++; $display("[TB] FAIL rst midEMIT blkLast: got %0b want 0", blkLast); end
    blkBusy = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    test_abc("postReset abc");
  endtask

  initial begin
    $display("[TB] sha_msg_padder directed bench");
    test_reset();
    test_abc("abc");
    test_55bytes();
    test_56bytes();
    test_64bytes();
    test_backpressure();
    test_reset_midblock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
    $finish;
  end

endmodule
